// File: rtl/cnn_ot_serializer_pkg.sv
// Shared geometry and helpers for the cnn_core output serializer.
// The input-side loader uses the same word count and index width.
package cnn_ot_serializer_pkg;

  localparam int OCH       = 2;
  localparam int OX        = 4;
  localparam int OY        = 4;
  localparam int DATA_LEN  = 16;
  localparam int PIX       = OX * OY;
  localparam int OUT_WORDS = OCH * OX * OY;
  localparam int IDX_W     = $clog2(OUT_WORDS);
  localparam int CH_W      = (OCH > 1) ? $clog2(OCH) : 1;
  localparam int FMAP_W    = OUT_WORDS * DATA_LEN;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Clamp negative two's-complement words to zero when enabled.
  function automatic logic [DATA_LEN-1:0] relu_word(input logic [DATA_LEN-1:0] w,
                                                    input logic en);
    logic [DATA_LEN-1:0] r;
    if (en && w[DATA_LEN-1]) begin
      r = {DATA_LEN{1'b0}};
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_ot_serializer_if.sv
// Valid/ready word stream from the serializer toward the buffer or bus writer.
interface cnn_ot_serializer_if #(
  parameter int DATA_LEN = 16,
  parameter int CH_W     = 1
);
  logic                o_ot_valid;
  logic                i_ot_ready;
  logic [DATA_LEN-1:0] o_ot_data;
  logic [CH_W-1:0]     o_ot_ch;
  logic                o_ot_last;

  modport master (
    output o_ot_valid,
    output o_ot_data,
    output o_ot_ch,
    output o_ot_last,
    input  i_ot_ready
  );

  modport slave (
    input  o_ot_valid,
    input  o_ot_data,
    input  o_ot_ch,
    input  o_ot_last,
    output i_ot_ready
  );
endinterface

// File: rtl/cnn_ot_serializer.sv
// Captures one full cnn_core output map on its valid pulse and streams it out
// one word per beat, channel-major, with optional ReLU on each word.
module cnn_ot_serializer
  import cnn_ot_serializer_pkg::*;
#(
  parameter int ACT_RELU = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_soft_reset,
  input  logic              i_in_valid,
  input  logic [FMAP_W-1:0] i_in_fmap,
  output logic              o_busy,
  output logic              o_overflow,
  cnn_ot_serializer_if.master ot
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_WORDS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FMAP_W-1:0]   cap_q, cap_d;
  logic                ovf_q, ovf_d;
  logic                send_s;
  logic                hs_s;
  logic                is_last_s;
  logic                final_hs_s;
  logic [DATA_LEN-1:0] word_s;

  assign send_s     = (state_q == ST_SEND);
  assign hs_s       = send_s && ot.i_ot_ready;
  assign is_last_s  = (idx_q == LAST_IDX);
  assign final_hs_s = hs_s && is_last_s;

  // Next-state, index advance, frame capture and overflow tracking.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_in_valid) begin
          cap_d   = i_in_fmap;
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_SEND;
        end else begin
          idx_d   = {IDX_W{1'b0}};
        end
      end
      ST_SEND: begin
        if (hs_s && !is_last_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (final_hs_s && i_in_valid) begin
          // Back-to-back frame: the new map follows the last beat with no gap.
          cap_d = i_in_fmap;
          idx_d = {IDX_W{1'b0}};
        end else if (final_hs_s) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q;
        end
        if (i_in_valid && !final_hs_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State register; either reset source discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset || i_soft_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      cap_q   <= {FMAP_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Word mux; driven only from registered state so ready never reaches valid.
  always_comb begin
    word_s = cap_q[int'(idx_q)*DATA_LEN +: DATA_LEN];
  end

  assign ot.o_ot_valid = send_s;
  assign ot.o_ot_data  = send_s ? relu_word(word_s, ACT_RELU != 0) : {DATA_LEN{1'b0}};
  assign ot.o_ot_ch    = send_s ? CH_W'(idx_q / IDX_W'(PIX)) : {CH_W{1'b0}};
  assign ot.o_ot_last  = send_s && is_last_s;
  assign o_busy        = send_s;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_cnn_ot_serializer.sv
// Directed bench for cnn_ot_serializer: a pass-through and a ReLU instance
// share one stimulus stream.
module tb_cnn_ot_serializer;
  import cnn_ot_serializer_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              soft_reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [FMAP_W-1:0] in_fmap = '0;
  logic              ready = 1'b0;
  logic              busy0, busy1, ovf0, ovf1;
  int                tests = 0;
  int                fails = 0;
  int                cyc;

  cnn_ot_serializer_if #(.DATA_LEN(DATA_LEN), .CH_W(CH_W)) ot0 ();
  cnn_ot_serializer_if #(.DATA_LEN(DATA_LEN), .CH_W(CH_W)) ot1 ();
  assign ot0.i_ot_ready = ready;
  assign ot1.i_ot_ready = ready;

  cnn_ot_serializer #(.ACT_RELU(0)) dut0 (
    .clk(clk), .reset(reset), .i_soft_reset(soft_reset), .i_in_valid(in_valid),
    .i_in_fmap(in_fmap), .o_busy(busy0), .o_overflow(ovf0), .ot(ot0));
  cnn_ot_serializer #(.ACT_RELU(1)) dut1 (
    .clk(clk), .reset(reset), .i_soft_reset(soft_reset), .i_in_valid(in_valid),
    .i_in_fmap(in_fmap), .o_busy(busy1), .o_overflow(ovf1), .ot(ot1));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in_word;
    logic [15:0] exp_pass;
    logic [15:0] exp_relu;
  } relu_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FMAP_W-1:0] make_frame(input int base);
    logic [FMAP_W-1:0] f;
    f = '0;
    for (int k = 0; k < OUT_WORDS; k++) f[k*DATA_LEN +: DATA_LEN] = DATA_LEN'(base + k);
    return f;
  endfunction

  task automatic pulse(input logic [FMAP_W-1:0] f);
    in_fmap  = f;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_beat(input int base, input int k);
    check($sformatf("valid[%0d]", k), 32'(ot0.o_ot_valid), 32'd1);
    check($sformatf("busy[%0d]", k), 32'(busy0), 32'd1);
    check($sformatf("data[%0d]", k), 32'(ot0.o_ot_data), 32'((base + k) & 16'hFFFF));
    check($sformatf("relu_data[%0d]", k), 32'(ot1.o_ot_data), 32'((base + k) & 16'hFFFF));
    check($sformatf("ch[%0d]", k), 32'(ot0.o_ot_ch), 32'(k / PIX));
    check($sformatf("last[%0d]", k), 32'(ot0.o_ot_last), (k == OUT_WORDS - 1) ? 32'd1 : 32'd0);
  endtask

  // Walks a frame already on the output; optional stall, drop pulse, chained
  // frame at the final handshake, or early stop (no step after word stop_at).
  task automatic stream(input int base, input int stall_at, input int drop_at,
                        input int chain_base, input int stop_at, output int cycles);
    cycles = 0;
    for (int k = 0; k < OUT_WORDS; k++) begin
      if (k == stall_at) begin
        for (int j = 0; j < 3; j++) begin
          ready = 1'b0;
          check_beat(base, k);
          step();
          cycles++;
        end
      end
      ready = 1'b1;
      check_beat(base, k);
      if (k == stop_at) return;
      if (k == drop_at) begin
        in_fmap  = make_frame(200);
        in_valid = 1'b1;
      end
      if (k == OUT_WORDS - 1 && chain_base >= 0) begin
        in_fmap  = make_frame(chain_base);
        in_valid = 1'b1;
      end
      step();
      cycles++;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_ovf);
    check({tag, "_valid"}, 32'(ot0.o_ot_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_last"}, 32'(ot0.o_ot_last), 32'd0);
    check({tag, "_ovf"}, 32'(ovf0), exp_ovf);
  endtask

  initial begin
    relu_vec_t vecs[6];
    logic [FMAP_W-1:0] rf;
    logic [15:0] e0, e1;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[1] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{16'h0001, 16'h0001, 16'h0001};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{16'hFF80, 16'hFF80, 16'h0000};

    step(); step(); step();
    reset = 1'b0;
    check_idle("reset", 32'd0);
    check("reset_data", 32'(ot0.o_ot_data), 32'd0);
    check("reset_ch", 32'(ot0.o_ot_ch), 32'd0);
    ready = 1'b1;

    // Plain frame, ready held high.
    pulse(make_frame(1));
    stream(1, -1, -1, -1, -1, cyc);
    check("t1_cycles", 32'(cyc), 32'd32);
    check_idle("t1_end", 32'd0);

    // Backpressure on word index 3.
    step();
    pulse(make_frame(1));
    stream(1, 3, -1, -1, -1, cyc);
    check("t2_cycles", 32'(cyc), 32'd35);
    check_idle("t2_end", 32'd0);

    // Back-to-back frames: second pulse on the final handshake.
    step();
    pulse(make_frame(1));
    stream(1, -1, -1, 100, -1, cyc);
    check("t3_ovf_mid", 32'(ovf0), 32'd0);
    stream(100, -1, -1, -1, -1, cyc);
    check_idle("t3_end", 32'd0);

    // Dropped pulse while data 10 (index 9) is presented.
    step();
    pulse(make_frame(1));
    stream(1, -1, 9, -1, -1, cyc);
    check_idle("t4_end", 32'd1);
    step(); step();
    check_idle("t4_hold", 32'd1);

    // Soft reset while data 5 (index 4) is presented, then restart.
    pulse(make_frame(1));
    stream(1, -1, -1, -1, 4, cyc);
    check("t5_ovf_before", 32'(ovf0), 32'd1);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    check_idle("t5_sreset", 32'd0);
    step();
    check_idle("t5_after", 32'd0);
    pulse(make_frame(50));
    stream(50, -1, -1, -1, -1, cyc);
    check_idle("t5_end", 32'd0);

    // Hard reset mid-frame aborts with no last beat.
    pulse(make_frame(1));
    stream(1, -1, -1, -1, 20, cyc);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("t6_reset", 32'd0);
    check("t6_data", 32'(ot0.o_ot_data), 32'd0);

    // ReLU table on both instances.
    rf = '0;
    for (int i = 0; i < 6; i++) rf[i*DATA_LEN +: DATA_LEN] = vecs[i].in_word;
    step();
    pulse(rf);
    for (int k = 0; k < OUT_WORDS; k++) begin
      e0 = (k < 6) ? vecs[k].exp_pass : 16'h0000;
      e1 = (k < 6) ? vecs[k].exp_relu : 16'h0000;
      check($sformatf("relu_valid[%0d]", k), 32'(ot1.o_ot_valid), 32'd1);
      check($sformatf("pass_word[%0d]", k), 32'(ot0.o_ot_data), 32'(e0));
      check($sformatf("relu_word[%0d]", k), 32'(ot1.o_ot_data), 32'(e1));
      step();
    end
    check("t7_relu_idle", 32'(ot1.o_ot_valid), 32'd0);
    check("t7_relu_ovf", 32'(ovf1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
